// File: rtl/bitmap_pkg.sv
// bitmap_pkg: shared types and constants for the multi-dot bitmap generator.
`default_nettype none

package bitmap_pkg;

    typedef enum logic {
        DRAW  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic DIR_P = 1'b0;
    localparam logic DIR_N = 1'b1;

    function automatic int bmp_addr_w(input int x_bits, input int y_bits);
        return x_bits + y_bits;
    endfunction

endpackage

`default_nettype wire

// File: rtl/bitmap_gen_multi_dot.sv
// bitmap_dot: position and bounce direction of one dot, with load and per-frame move.
`default_nettype none

module bitmap_dot
    import bitmap_pkg::*;
#(
    parameter int X_BITS = 7,
    parameter int Y_BITS = 7,
    parameter int INIT_X = 1,
    parameter int INIT_Y = 1
) (
    input  logic              clk,
    input  logic              rst_i,
    input  logic              move_i,
    input  logic              load_i,
    input  logic [X_BITS-1:0] ld_x_i,
    input  logic [Y_BITS-1:0] ld_y_i,
    output logic [X_BITS-1:0] x_o,
    output logic [Y_BITS-1:0] y_o
);

    localparam int MAX_X = 1 << X_BITS;
    localparam int MAX_Y = 1 << Y_BITS;

    logic [X_BITS-1:0] x_q, x_d;
    logic [Y_BITS-1:0] y_q, y_d;
    logic              dir_x_q, dir_x_d;
    logic              dir_y_q, dir_y_d;

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (load_i) begin
            x_d = ld_x_i;
            y_d = ld_y_i;
        end else if (move_i) begin
            x_d = (dir_x_q == DIR_P) ? x_q + 1'b1 : x_q - 1'b1;
            y_d = (dir_y_q == DIR_P) ? y_q + 1'b1 : y_q - 1'b1;
        end
        // Direction tracks the current position every clock, independent of moves.
        dir_x_d = (x_q == X_BITS'(1))       ? DIR_P :
                  (x_q == X_BITS'(MAX_X-2)) ? DIR_N : dir_x_q;
        dir_y_d = (y_q == Y_BITS'(1))       ? DIR_P :
                  (y_q == Y_BITS'(MAX_Y-2)) ? DIR_N : dir_y_q;
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            x_q     <= X_BITS'(INIT_X);
            y_q     <= Y_BITS'(INIT_Y);
            dir_x_q <= DIR_P;
            dir_y_q <= DIR_P;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            dir_x_q <= dir_x_d;
            dir_y_q <= dir_y_d;
        end
    end

    assign x_o = x_q;
    assign y_o = y_q;

endmodule

`default_nettype wire

// File: rtl/debounce.sv
// debounce: two-flop synchroniser plus stability counter; one-clock tick on a debounced rising edge.
`default_nettype none

module debounce #(
    parameter int CNT_BITS = 20
) (
    input  logic clk,
    input  logic rst_i,
    input  logic btn_i,
    output logic tick_o
);

    logic [1:0]          sync_q;
    logic                stable_q;
    logic                tick_q;
    logic [CNT_BITS-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            tick_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            tick_q <= 1'b0;
            if (sync_q[1] == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == {CNT_BITS{1'b1}}) begin
                // Input held its new level for the full window: accept it.
                stable_q <= sync_q[1];
                tick_q   <= sync_q[1];
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign tick_o = tick_q;

endmodule

`default_nettype wire

// File: rtl/xilinx_dual_port_ram_sync.sv
// xilinx_dual_port_ram_sync: port A write-only, port B synchronous read with one clock latency.
`default_nettype none

module xilinx_dual_port_ram_sync #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_a_i,
    input  logic [ADDR_WIDTH-1:0] addr_b_i,
    input  logic [DATA_WIDTH-1:0] din_a_i,
    output logic [DATA_WIDTH-1:0] dout_b_o
);

    logic [DATA_WIDTH-1:0] ram [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] dout_b_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            ram[addr_a_i] <= din_a_i;
        end
        dout_b_q <= ram[addr_b_i];
    end

    assign dout_b_o = dout_b_q;

endmodule

`default_nettype wire

// File: rtl/bitmap_gen_multi.sv
// bitmap_gen_multi: frame-buffer bitmap with NUM_DOTS bouncing painters and a button-driven clear sweep.
// Optional BITMAP_DOT_COLOR_EN gives each dot the colour sw ^ index.
`default_nettype none

module bitmap_gen_multi
    import bitmap_pkg::*;
#(
    parameter int                BMP_X_BITS  = 7,
    parameter int                BMP_Y_BITS  = 7,
    parameter int                COLOR_W     = 3,
    parameter int                NUM_DOTS    = 4,
    parameter int                V_REFR_LINE = 481,
    parameter logic [COLOR_W-1:0] BG_COLOR   = 3'b110,
    parameter int                DB_CNT_BITS = 20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               video_on,
    input  logic [1:0]         btn,
    input  logic [COLOR_W-1:0] sw,
    input  logic [9:0]         pix_x,
    input  logic [9:0]         pix_y,
    output logic [COLOR_W-1:0] bit_rgb,
    output logic               clr_busy
);

    localparam int ADDR_W = bmp_addr_w(BMP_X_BITS, BMP_Y_BITS);
    localparam int MAX_X  = 1 << BMP_X_BITS;
    localparam int MAX_Y  = 1 << BMP_Y_BITS;
    localparam int IDX_W  = (NUM_DOTS > 1) ? $clog2(NUM_DOTS) : 1;

    state_t              state_q;
    logic [ADDR_W-1:0]   clr_addr_q;
    logic [IDX_W-1:0]    load_ptr_q;
    logic [IDX_W-1:0]    wr_idx_q;
    logic                bm_on_q;
    logic                video_on_q;

    logic                refr_tick, load_tick, clr_tick;
    logic                draw, clr_go, load_go, move;
    logic                bm_on;
    logic [ADDR_W-1:0]   addr_a, addr_b;
    logic [COLOR_W-1:0]  din_a, dout_b;

    logic [BMP_X_BITS-1:0] dot_x [NUM_DOTS];
    logic [BMP_Y_BITS-1:0] dot_y [NUM_DOTS];

    assign refr_tick = (pix_y == 10'(V_REFR_LINE)) && (pix_x == 10'd0);

    debounce #(.CNT_BITS(DB_CNT_BITS)) u_db_load (
        .clk   (clk),
        .rst_i (reset),
        .btn_i (btn[0]),
        .tick_o(load_tick)
    );

    debounce #(.CNT_BITS(DB_CNT_BITS)) u_db_clr (
        .clk   (clk),
        .rst_i (reset),
        .btn_i (btn[1]),
        .tick_o(clr_tick)
    );

    // A clear request wins over a simultaneous load; that load is dropped.
    assign draw    = (state_q == DRAW);
    assign clr_go  = draw && clr_tick;
    assign load_go = draw && load_tick && !clr_tick;
    assign move    = draw && refr_tick;

    generate
        for (genvar i = 0; i < NUM_DOTS; i++) begin : g_dots
            bitmap_dot #(
                .X_BITS(BMP_X_BITS),
                .Y_BITS(BMP_Y_BITS),
                .INIT_X((8*i + 1) % MAX_X),
                .INIT_Y((16*i + 1) % MAX_Y)
            ) u_dot (
                .clk   (clk),
                .rst_i (reset),
                .move_i(move),
                .load_i(load_go && (load_ptr_q == IDX_W'(i))),
                .ld_x_i(pix_x[BMP_X_BITS-1:0]),
                .ld_y_i(pix_y[BMP_Y_BITS-1:0]),
                .x_o   (dot_x[i]),
                .y_o   (dot_y[i])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= DRAW;
            clr_addr_q <= '0;
            load_ptr_q <= '0;
            wr_idx_q   <= '0;
            bm_on_q    <= 1'b0;
            video_on_q <= 1'b0;
        end else begin
            wr_idx_q   <= (wr_idx_q == IDX_W'(NUM_DOTS-1)) ? '0 : wr_idx_q + 1'b1;
            bm_on_q    <= bm_on;
            video_on_q <= video_on;
            case (state_q)
                DRAW: begin
                    if (clr_go) begin
                        state_q <= CLEAR;
                    end else if (load_go) begin
                        load_ptr_q <= (load_ptr_q == IDX_W'(NUM_DOTS-1)) ? '0 : load_ptr_q + 1'b1;
                    end
                end
                CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == {ADDR_W{1'b1}}) begin
                        state_q <= DRAW;
                    end
                end
                default: state_q <= DRAW;
            endcase
        end
    end

    always_comb begin
        addr_a = {dot_y[wr_idx_q], dot_x[wr_idx_q]};
`ifdef BITMAP_DOT_COLOR_EN
        din_a  = sw ^ COLOR_W'(wr_idx_q);
`else
        din_a  = sw;
`endif
        if (state_q == CLEAR) begin
            addr_a = clr_addr_q;
            din_a  = '0;
        end
    end

    assign addr_b = {pix_y[BMP_Y_BITS-1:0], pix_x[BMP_X_BITS-1:0]};
    assign bm_on  = ({1'b0, pix_x} < 11'(MAX_X)) && ({1'b0, pix_y} < 11'(MAX_Y));

    xilinx_dual_port_ram_sync #(
        .ADDR_WIDTH(ADDR_W),
        .DATA_WIDTH(COLOR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (1'b1),
        .addr_a_i(addr_a),
        .addr_b_i(addr_b),
        .din_a_i (din_a),
        .dout_b_o(dout_b)
    );

    assign bit_rgb  = !video_on_q ? '0 : (bm_on_q ? dout_b : BG_COLOR);
    assign clr_busy = (state_q == CLEAR);

endmodule

`default_nettype wire

// File: tb/tb_bitmap_gen_multi.sv
// tb_bitmap_gen_multi: directed checks of painting, bounce, load order, clear sweep and reset.
`default_nettype none

module tb_bitmap_gen_multi;

    logic       clk = 1'b0;
    logic       reset;
    logic       video_on;
    logic [1:0] btn;
    logic [2:0] sw;
    logic [9:0] pix_x, pix_y;
    logic [2:0] bit_rgb;
    logic       clr_busy;

    int checks   = 0;
    int failures = 0;
    int n;

    always #5 clk = ~clk;

    bitmap_gen_multi #(.DB_CNT_BITS(2)) dut (
        .clk     (clk),
        .reset   (reset),
        .video_on(video_on),
        .btn     (btn),
        .sw      (sw),
        .pix_x   (pix_x),
        .pix_y   (pix_y),
        .bit_rgb (bit_rgb),
        .clr_busy(clr_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic park();
        pix_x = 10'd300;
        pix_y = 10'd300;
    endtask

    task automatic refr();
        pix_x = 10'd0;
        pix_y = 10'd481;
        cyc(1);
        park();
    endtask

    task automatic press(input int b, input int px, input int py);
        pix_x  = 10'(px);
        pix_y  = 10'(py);
        btn[b] = 1'b1;
        cyc(12);
        btn[b] = 1'b0;
        cyc(12);
        park();
    endtask

    task automatic read_px(input int px, input int py);
        pix_x = 10'(px);
        pix_y = 10'(py);
        cyc(1);
    endtask

    task automatic check_dot(input string tag, input int i, input int ex, input int ey);
        check({tag, "_x"}, 32'(dut.dot_x[i]), 32'(ex));
        check({tag, "_y"}, 32'(dut.dot_y[i]), 32'(ey));
    endtask

    initial begin
        reset    = 1'b1;
        video_on = 1'b1;
        btn      = 2'b00;
        sw       = 3'b101;
        park();
        cyc(3);

        // Reset state
        check("rst_rgb", 32'(bit_rgb), 0);
        check("rst_busy", 32'(clr_busy), 0);
        check("rst_state", 32'(dut.state_q), 0);
        check("rst_ptr", 32'(dut.load_ptr_q), 0);
        check("rst_clr_addr", 32'(dut.clr_addr_q), 0);
        check_dot("rst_dot0", 0, 1, 1);
        check_dot("rst_dot1", 1, 9, 17);
        check_dot("rst_dot3", 3, 25, 49);
        reset = 1'b0;
        cyc(2);

        // Three frames of motion, then read back the painted pixels
        refr(); cyc(2);
        refr(); cyc(2);
        refr(); cyc(8);
        check_dot("move_dot0", 0, 4, 4);
        check_dot("move_dot1", 1, 12, 20);
        read_px(4, 4);
        check("paint_dot0", 32'(bit_rgb), 5);
        read_px(12, 20);
        check("paint_dot1", 32'(bit_rgb), 5);

        // Window and blanking
        read_px(200, 50);
        check("bg_color", 32'(bit_rgb), 6);
        video_on = 1'b0;
        read_px(4, 4);
        check("blank", 32'(bit_rgb), 0);
        video_on = 1'b1;
        read_px(4, 4);
        check("unblank", 32'(bit_rgb), 5);
        park();

        // Load round-robin: 0,1,2,3,0
        press(0, 10, 20);  check_dot("ld0", 0, 10, 20); check("ld0_ptr", 32'(dut.load_ptr_q), 1);
        press(0, 30, 40);  check_dot("ld1", 1, 30, 40); check("ld1_ptr", 32'(dut.load_ptr_q), 2);
        press(0, 50, 60);  check_dot("ld2", 2, 50, 60); check("ld2_ptr", 32'(dut.load_ptr_q), 3);
        press(0, 70, 80);  check_dot("ld3", 3, 70, 80); check("ld3_ptr", 32'(dut.load_ptr_q), 0);
        press(0, 90, 100); check_dot("ld4", 0, 90, 100); check("ld4_ptr", 32'(dut.load_ptr_q), 1);
        check_dot("ld4_dot1_kept", 1, 30, 40);

        // High-edge bounce on dot0
        press(0, 20, 20);
        press(0, 30, 30);
        press(0, 40, 40);
        press(0, 125, 60);
        check_dot("hi_load", 0, 125, 60);
        refr();
        check_dot("hi_tick1", 0, 126, 61);
        cyc(2);
        refr();
        check_dot("hi_tick2", 0, 125, 62);

        // Low-edge bounce: dot0 keeps its -1 direction through a load
        press(0, 20, 20);
        press(0, 30, 30);
        press(0, 40, 40);
        press(0, 2, 60);
        check_dot("lo_load", 0, 2, 60);
        check("lo_ptr", 32'(dut.load_ptr_q), 1);
        refr();
        check_dot("lo_tick1", 0, 1, 61);
        cyc(2);
        refr();
        check_dot("lo_tick2", 0, 2, 62);
        check_dot("lo_dot1", 1, 22, 22);
        cyc(4);

        // Clear sweep, with a load press and a refresh tick inside it
        btn[1] = 1'b1;
        n = 0;
        while (!clr_busy && n < 50) begin
            cyc(1);
            n++;
        end
        check("clr_start", 32'(clr_busy), 1);
        n = 0;
        while (clr_busy && n < 20000) begin
            cyc(1);
            n++;
            if (n == 20)  btn[1] = 1'b0;
            if (n == 100) btn[0] = 1'b1;
            if (n == 115) btn[0] = 1'b0;
            if (n == 200) begin pix_x = 10'd0; pix_y = 10'd481; end
            if (n == 201) park();
        end
        check("clr_len", 32'(n), 16384);
        check("clr_done_state", 32'(dut.state_q), 0);
        check("clr_ptr_kept", 32'(dut.load_ptr_q), 1);
        check_dot("clr_frozen", 0, 2, 62);
        cyc(8);
        read_px(4, 4);     check("clr_zero_a", 32'(bit_rgb), 0);
        read_px(90, 100);  check("clr_zero_b", 32'(bit_rgb), 0);
        read_px(0, 0);     check("clr_zero_c", 32'(bit_rgb), 0);
        read_px(127, 127); check("clr_zero_d", 32'(bit_rgb), 0);
        read_px(22, 22);   check("repaint", 32'(bit_rgb), 5);
        park();
        refr();
        check_dot("resume", 0, 3, 63);

        // Reset asserted mid-clear
        btn[1] = 1'b1;
        n = 0;
        while (!clr_busy && n < 50) begin
            cyc(1);
            n++;
        end
        check("clr2_start", 32'(clr_busy), 1);
        n = 0;
        while (dut.clr_addr_q != 14'd5000 && n < 6000) begin
            cyc(1);
            n++;
        end
        check("clr2_reach", 32'(dut.clr_addr_q), 5000);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(clr_busy), 0);
        check("mid_rst_state", 32'(dut.state_q), 0);
        check("mid_rst_clr_addr", 32'(dut.clr_addr_q), 0);
        check("mid_rst_ptr", 32'(dut.load_ptr_q), 0);
        check("mid_rst_rgb", 32'(bit_rgb), 0);
        check_dot("mid_rst_dot0", 0, 1, 1);
        check_dot("mid_rst_dot2", 2, 17, 33);
        btn[1] = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
